// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory for the memory pipeline stage.
// One request is accepted at a time. It is held for LATENCY cycles, then the
// write is committed or the read data is returned with a one-cycle done pulse.
// Illegal requests are rejected with a one-cycle err pulse and no array access.
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [15:0]       data_out_q, data_out_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [15:0]       mem_q [2**ADDR_W];
  logic              mem_we;

  logic              req;
  logic              illegal;

  // Classify the incoming request: both ops at once, odd byte address, or
  // any address bit above the word-index range makes it illegal.
  always_comb begin
    req     = rd | wr;
    illegal = (rd & wr) | addr[0] | ((addr >> (ADDR_W + 1)) != 16'd0);
  end

  // Next-state logic: accept in IDLE, count down in BUSY, finish at zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            idx_d   = addr[ADDR_W:1];
            wdata_d = data_in;
            is_wr_d = wr;
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (is_wr_q) begin
            mem_we = 1'b1;
          end else begin
            data_out_d = mem_q[idx_q];
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 16'd0;
      is_wr_q    <= 1'b0;
      data_out_q <= 16'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Storage array: cleared on reset, written only on a write completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem_q[i] <= 16'd0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;
  assign err      = err_q;
  assign stall    = (state_q == BUSY);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance at LATENCY=4 and one at
// LATENCY=1, checked against a transaction-level memory model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [15:0] dout_a, dout_b;
  logic        done_a, done_b, stall_a, stall_b, err_a, err_b;

  logic        sel;
  logic [15:0] dout_s;
  logic        done_s, stall_s, err_s;

  int          total = 0;
  int          bad   = 0;

  logic [15:0] model_mem  [2][256];
  logic [15:0] model_dout [2];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .LATENCY(4)) u_a (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd_a), .wr(wr_a),
    .data_out(dout_a), .done(done_a), .stall(stall_a), .err(err_a)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(1)) u_b (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd_b), .wr(wr_b),
    .data_out(dout_b), .done(done_b), .stall(stall_b), .err(err_b)
  );

  assign dout_s  = sel ? dout_b  : dout_a;
  assign done_s  = sel ? done_b  : done_a;
  assign stall_s = sel ? stall_b : stall_a;
  assign err_s   = sel ? err_b   : err_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      model_dout[d] = 16'd0;
      for (int w = 0; w < 256; w++) model_mem[d][w] = 16'd0;
    end
  endtask

  task automatic drive_req(input logic r, input logic w);
    if (sel) begin
      rd_b = r; wr_b = w;
    end else begin
      rd_a = r; wr_a = w;
    end
  endtask

  function automatic bit is_legal(input logic r, input logic w, input logic [15:0] a);
    return !(r && w) && (a % 2 == 0) && (a < 16'd512);
  endfunction

  // One legal access presented in the current cycle; ends in its done cycle
  task automatic run_access(input logic use_b, input logic is_wr, input logic [15:0] a,
                            input logic [15:0] d, input logic stray, input string tag);
    int          lat;
    logic [15:0] exp;
    sel = use_b;
    lat = use_b ? 1 : 4;
    addr = a;
    data_in = d;
    drive_req(!is_wr, is_wr);
    tick();
    for (int i = 0; i < lat; i++) begin
      total++;
      if ({stall_s, done_s, err_s} !== 3'b100) begin
        bad++;
        $display("[TB] FAIL %s busy%0d: stall/done/err=%b expected 100", tag, i,
                 {stall_s, done_s, err_s});
      end
      if (stray) begin
        addr = a ^ 16'h0040;
        data_in = ~d;
        drive_req(1'b0, 1'((i % 2) == 0));
      end
      tick();
    end
    if (is_wr) model_mem[use_b][a[8:1]] = d;
    else model_dout[use_b] = model_mem[use_b][a[8:1]];
    exp = model_dout[use_b];
    total++;
    if ({stall_s, done_s, err_s} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL %s done: stall/done/err=%b expected 010", tag, {stall_s, done_s, err_s});
    end
    total++;
    if (dout_s !== exp) begin
      bad++;
      $display("[TB] FAIL %s data_out: got %h expected %h", tag, dout_s, exp);
    end
    addr = a;
    data_in = d;
    drive_req(1'b0, 1'b0);
  endtask

  // One rejected request: err next cycle, then quiet
  task automatic run_illegal(input logic use_b, input logic r, input logic w,
                             input logic [15:0] a, input string tag);
    sel = use_b;
    addr = a;
    data_in = 16'hDEAD;
    drive_req(r, w);
    tick();
    total++;
    if ({stall_s, done_s, err_s} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL %s err: stall/done/err=%b expected 001", tag, {stall_s, done_s, err_s});
    end
    drive_req(1'b0, 1'b0);
    tick();
    total++;
    if ({stall_s, done_s, err_s} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL %s after: stall/done/err=%b expected 000", tag, {stall_s, done_s, err_s});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    addr = 16'd0; data_in = 16'd0;
    rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    sel = 1'b0;
    clear_model();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({dout_a, stall_a, done_a, err_a} !== 19'd0) begin
      bad++;
      $display("[TB] FAIL reset_a: data_out=%h stall/done/err=%b expected 0", dout_a,
               {stall_a, done_a, err_a});
    end
    total++;
    if ({dout_b, stall_b, done_b, err_b} !== 19'd0) begin
      bad++;
      $display("[TB] FAIL reset_b: data_out=%h stall/done/err=%b expected 0", dout_b,
               {stall_b, done_b, err_b});
    end
  endtask

  task automatic test_write_read();
    run_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, "wr_0010");
    tick();
    total++;
    if ({stall_s, done_s, err_s} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL idle_gap: stall/done/err=%b expected 000", {stall_s, done_s, err_s});
    end
    run_access(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, "rd_0010");
    tick();
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 16'h0014, 16'h5555, 1'b0, "b2b_wr");
    run_access(1'b0, 1'b0, 16'h0012, 16'h0000, 1'b0, "b2b_rd0012");
    run_access(1'b0, 1'b0, 16'h0014, 16'h0000, 1'b0, "b2b_rd0014");
    tick();
  endtask

  task automatic test_illegal();
    run_illegal(1'b0, 1'b1, 1'b0, 16'h0011, "unaligned");
    run_illegal(1'b0, 1'b1, 1'b0, 16'h0400, "range");
    run_illegal(1'b0, 1'b1, 1'b1, 16'h0010, "rdwr");
    run_access(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, "rd_after_err");
    tick();
  endtask

  task automatic test_busy_ignore();
    run_access(1'b0, 1'b1, 16'h0030, 16'h7777, 1'b1, "stray_wr");
    run_access(1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0, "stray_rd0030");
    run_access(1'b0, 1'b0, 16'h0070, 16'h0000, 1'b0, "stray_rd0070");
    tick();
  endtask

  task automatic test_reset_mid_write();
    sel = 1'b0;
    addr = 16'h0020;
    data_in = 16'h1234;
    drive_req(1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    drive_req(1'b0, 1'b0);
    tick();
    total++;
    if ({dout_a, stall_a, done_a, err_a} !== 19'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset: data_out=%h stall/done/err=%b expected 0", dout_a,
               {stall_a, done_a, err_a});
    end
    rst = 1'b0;
    clear_model();
    tick();
    total++;
    if ({stall_a, done_a, err_a} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL mid_reset_idle: stall/done/err=%b expected 000", {stall_a, done_a, err_a});
    end
    run_access(1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, "rd_after_reset");
    tick();
  endtask

  task automatic test_min_latency();
    run_access(1'b1, 1'b1, 16'h00FE, 16'hA5A5, 1'b0, "min_wr");
    tick();
    run_access(1'b1, 1'b0, 16'h00FE, 16'h0000, 1'b0, "min_rd");
    run_access(1'b1, 1'b1, 16'h0010, 16'h0F0F, 1'b1, "min_stray");
    run_access(1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, "min_rd0050");
    tick();
  endtask

  task automatic test_random();
    logic        use_b, r, w;
    logic [15:0] a, d;
    for (int n = 0; n < 60; n++) begin
      use_b = 1'($urandom_range(0, 1));
      d     = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a = 16'($urandom);
        r = 1'($urandom_range(0, 1));
        w = r ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        a = 16'($urandom_range(0, 15) * 2);
        w = 1'($urandom_range(0, 1));
        r = !w;
      end
      if (is_legal(r, w, a))
        run_access(use_b, w, a, d, 1'($urandom_range(0, 3) == 0), "rand_acc");
      else
        run_illegal(use_b, r, w, a, "rand_err");
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_illegal();
    test_busy_ignore();
    test_reset_mid_write();
    test_min_latency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
